// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Shares one external 32-bit combinational left barrel shifter between two
// requesters (req0 = ALU, req1 = multdiv unit). One operation is in flight at
// a time. The winning request's operands are registered onto sh_a/sh_amt. The
// shifter result is captured one cycle later and returned to the owner over a
// valid/ready response channel.
//
// Sequence: IDLE -> ISSUE -> RESP -> IDLE. A request is accepted in cycle c
// and its response is valid in cycle c+2. Each operation takes at least three
// cycles.
//
// Configuration:
//   FIXED_PRIO            0 = round-robin on conflict, 1 = req0 always wins
//   SHIFT_ZERO_BYPASS_EN  (macro) when defined, an accepted op with amt == 0
//                         skips ISSUE. Its operand is loaded straight into the
//                         result, so the response is valid in cycle c+1, and
//                         sh_a/sh_amt are left untouched.
//
// Ports:
//   clock, reset               single clock, synchronous active-high reset
//   req{0,1}_valid/ready       request handshake; ready is a combinational
//                              grant, high only in IDLE
//   req{0,1}_a, req{0,1}_amt   operand and left-shift amount (0..31)
//   sh_a, sh_amt               registered operands to the shared shifter
//   sh_out                     shifter result (combinational from sh_a/sh_amt)
//   rsp{0,1}_valid/ready/data  response channel; only the owner's valid is high
//   busy                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module shift_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_amt,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_amt,

  output logic [31:0] sh_a,
  output logic [4:0]  sh_amt,
  input  logic [31:0] sh_out,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        owner;       // 0 = req0 owns the in-flight op, 1 = req1
  logic        last_grant;  // requester granted most recently
  logic [31:0] result;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [31:0] accept_a;
  logic [4:0]  accept_amt;
  logic        bypass;
  logic        rsp_fire;

  // Grant logic. Ready is only offered in IDLE and never while reset is
  // asserted. On a conflict, round-robin hands the grant to the requester that
  // did not win last time.
  // NOTE: every signal written in an always_comb gets a default at the top so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_PRIO != 0 || last_grant) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept     = grant0 | grant1;
  assign accept_a   = grant1 ? req1_a   : req0_a;
  assign accept_amt = grant1 ? req1_amt : req0_amt;

`ifdef SHIFT_ZERO_BYPASS_EN
  // A zero shift is the identity, so the shifter round trip can be skipped.
  assign bypass = (accept_amt == 5'd0);
`else
  assign bypass = 1'b0;
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign rsp0_data  = rsp0_valid ? result : 32'd0;
  assign rsp1_data  = rsp1_valid ? result : 32'd0;
  assign busy       = (state != IDLE);

  // Only the owner's handshake can complete a response. A ready seen while the
  // matching valid is low is ignored.
  assign rsp_fire = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bypass ? RESP : ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments, so every
  // register samples pre-edge values and the order of statements does not
  // matter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath. sh_a/sh_amt change only when an op is accepted for the shifter,
  // so the shared shifter inputs stay quiet while idle or bypassing.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_a       <= 32'd0;
      sh_amt     <= 5'd0;
      result     <= 32'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        if (bypass) begin
          result <= accept_a;
        end else begin
          sh_a   <= accept_a;
          sh_amt <= accept_amt;
        end
      end
      if (state == ISSUE) begin
        result <= sh_out;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Drives two shift_arbiter instances: index 0 with FIXED_PRIO=0 (round-robin)
// and index 1 with FIXED_PRIO=1. Each instance gets its own behavioural
// shifter. Expected grants, results and latencies come from a
// transaction-level model: the winner is chosen from the arbitration rules,
// and the result is (a * 2^amt) mod 2^32. Outputs are sampled on the falling
// edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       reset;
  logic [1:0]       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0][31:0] req0_a, req1_a;
  logic [1:0][4:0]  req0_amt, req1_amt;
  logic [1:0][31:0] sh_a, sh_out;
  logic [1:0][4:0]  sh_amt;
  logic [1:0]       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [1:0][31:0] rsp0_data, rsp1_data;
  logic [1:0]       busy;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    // External combinational shifter seen by the arbiter.
    assign sh_out[g] = sh_a[g] << sh_amt[g];

    shift_arbiter #(.FIXED_PRIO(g)) u_dut (
      .clock      (clock),
      .reset      (reset[g]),
      .req0_valid (req0_valid[g]),
      .req0_ready (req0_ready[g]),
      .req0_a     (req0_a[g]),
      .req0_amt   (req0_amt[g]),
      .req1_valid (req1_valid[g]),
      .req1_ready (req1_ready[g]),
      .req1_a     (req1_a[g]),
      .req1_amt   (req1_amt[g]),
      .sh_a       (sh_a[g]),
      .sh_amt     (sh_amt[g]),
      .sh_out     (sh_out[g]),
      .rsp0_valid (rsp0_valid[g]),
      .rsp0_ready (rsp0_ready[g]),
      .rsp0_data  (rsp0_data[g]),
      .rsp1_valid (rsp1_valid[g]),
      .rsp1_ready (rsp1_ready[g]),
      .rsp1_data  (rsp1_data[g]),
      .busy       (busy[g])
    );
  end

  int unsigned evaluated = 0;
  int unsigned failures  = 0;

  // Reference model state, one entry per instance.
  logic        mdl_last[2];
  logic [31:0] mdl_sh_a[2];
  logic [4:0]  mdl_sh_amt[2];

  function automatic logic [31:0] shl(input logic [31:0] a, input logic [4:0] amt);
    logic [63:0] p;
    p = {32'd0, a} * (64'd1 << amt);
    return p[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. Holds reset for one cycle with both requests
  // valid, then checks the post-reset outputs.
  task automatic do_reset(input int d);
    reset[d] = 1'b1;
    req0_valid[d] = 1'b1;
    req1_valid[d] = 1'b1;
    #1;
    check($sformatf("d%0d reset req0_ready", d), {31'd0, req0_ready[d]}, 32'd0);
    check($sformatf("d%0d reset req1_ready", d), {31'd0, req1_ready[d]}, 32'd0);
    @(negedge clock);
    reset[d] = 1'b0;
    req0_valid[d] = 1'b0;
    req1_valid[d] = 1'b0;
    rsp0_ready[d] = 1'b0;
    rsp1_ready[d] = 1'b0;
    #1;
    mdl_last[d]   = 1'b1;
    mdl_sh_a[d]   = 32'd0;
    mdl_sh_amt[d] = 5'd0;
    check($sformatf("d%0d post-reset busy", d), {31'd0, busy[d]}, 32'd0);
    check($sformatf("d%0d post-reset rsp0_valid", d), {31'd0, rsp0_valid[d]}, 32'd0);
    check($sformatf("d%0d post-reset rsp1_valid", d), {31'd0, rsp1_valid[d]}, 32'd0);
    check($sformatf("d%0d post-reset rsp0_data", d), rsp0_data[d], 32'd0);
    check($sformatf("d%0d post-reset rsp1_data", d), rsp1_data[d], 32'd0);
    check($sformatf("d%0d post-reset sh_a", d), sh_a[d], mdl_sh_a[d]);
    check($sformatf("d%0d post-reset sh_amt", d), {27'd0, sh_amt[d]}, {27'd0, mdl_sh_amt[d]});
  endtask

  // One complete transaction, started at a falling edge with the DUT in IDLE.
  // The response is held un-taken for `hold` extra cycles.
  task automatic run_op(input int d,
                        input logic v0, input logic [31:0] a0, input logic [4:0] m0,
                        input logic v1, input logic [31:0] a1, input logic [4:0] m1,
                        input int hold);
    int          win;
    logic [31:0] a, res;
    logic [4:0]  m;
    logic        byp;
    req0_valid[d] = v0; req0_a[d] = a0; req0_amt[d] = m0;
    req1_valid[d] = v1; req1_a[d] = a1; req1_amt[d] = m1;
    rsp0_ready[d] = 1'b0; rsp1_ready[d] = 1'b0;
    #1;
    if (v0 && !v1)      win = 0;
    else if (v1 && !v0) win = 1;
    else if (d == 1)    win = 0;
    else                win = mdl_last[d] ? 0 : 1;
    check($sformatf("d%0d accept req0_ready", d), {31'd0, req0_ready[d]}, {31'd0, win == 0});
    check($sformatf("d%0d accept req1_ready", d), {31'd0, req1_ready[d]}, {31'd0, win == 1});
    check($sformatf("d%0d accept busy", d), {31'd0, busy[d]}, 32'd0);
    a   = (win == 1) ? a1 : a0;
    m   = (win == 1) ? m1 : m0;
    res = shl(a, m);
`ifdef SHIFT_ZERO_BYPASS_EN
    byp = (m == 5'd0);
`else
    byp = 1'b0;
`endif
    mdl_last[d] = (win == 1);
    if (!byp) begin
      mdl_sh_a[d]   = a;
      mdl_sh_amt[d] = m;
    end

    // After acceptance the requesters may scribble on their inputs freely.
    @(posedge clock);
    #1;
    req0_valid[d] = 1'($urandom); req0_a[d] = $urandom; req0_amt[d] = 5'($urandom);
    req1_valid[d] = 1'($urandom); req1_a[d] = $urandom; req1_amt[d] = 5'($urandom);
    if (!byp) begin
      // Response ready while no response is valid must be ignored.
      rsp0_ready[d] = 1'b1;
      rsp1_ready[d] = 1'b1;
      @(negedge clock);
      check($sformatf("d%0d issue busy", d), {31'd0, busy[d]}, 32'd1);
      check($sformatf("d%0d issue req0_ready", d), {31'd0, req0_ready[d]}, 32'd0);
      check($sformatf("d%0d issue req1_ready", d), {31'd0, req1_ready[d]}, 32'd0);
      check($sformatf("d%0d issue rsp0_valid", d), {31'd0, rsp0_valid[d]}, 32'd0);
      check($sformatf("d%0d issue rsp1_valid", d), {31'd0, rsp1_valid[d]}, 32'd0);
      check($sformatf("d%0d issue sh_a", d), sh_a[d], mdl_sh_a[d]);
      check($sformatf("d%0d issue sh_amt", d), {27'd0, sh_amt[d]}, {27'd0, mdl_sh_amt[d]});
      rsp0_ready[d] = 1'b0;
      rsp1_ready[d] = 1'b0;
    end
    @(negedge clock);

    for (int i = 0; i <= hold; i++) begin
      // The non-owner's ready is asserted and must not complete anything.
      if (win == 0) rsp1_ready[d] = 1'b1;
      else          rsp0_ready[d] = 1'b1;
      #1;
      check($sformatf("d%0d resp owner valid (cyc %0d)", d, i),
            {31'd0, (win == 0) ? rsp0_valid[d] : rsp1_valid[d]}, 32'd1);
      check($sformatf("d%0d resp other valid (cyc %0d)", d, i),
            {31'd0, (win == 0) ? rsp1_valid[d] : rsp0_valid[d]}, 32'd0);
      check($sformatf("d%0d resp data (cyc %0d)", d, i),
            (win == 0) ? rsp0_data[d] : rsp1_data[d], res);
      check($sformatf("d%0d resp busy (cyc %0d)", d, i), {31'd0, busy[d]}, 32'd1);
      check($sformatf("d%0d resp req ready (cyc %0d)", d, i),
            {30'd0, req1_ready[d], req0_ready[d]}, 32'd0);
      check($sformatf("d%0d resp sh_a hold (cyc %0d)", d, i), sh_a[d], mdl_sh_a[d]);
      if (i == hold) begin
        if (win == 0) rsp0_ready[d] = 1'b1;
        else          rsp1_ready[d] = 1'b1;
      end
      @(negedge clock);
    end

    rsp0_ready[d] = 1'b0; rsp1_ready[d] = 1'b0;
    req0_valid[d] = 1'b0; req1_valid[d] = 1'b0;
    #1;
    check($sformatf("d%0d done rsp0_valid", d), {31'd0, rsp0_valid[d]}, 32'd0);
    check($sformatf("d%0d done rsp1_valid", d), {31'd0, rsp1_valid[d]}, 32'd0);
    check($sformatf("d%0d done busy", d), {31'd0, busy[d]}, 32'd0);
  endtask

  initial begin
    reset = 2'b11;
    req0_valid = '0; req1_valid = '0; rsp0_ready = '0; rsp1_ready = '0;
    req0_a = '0; req1_a = '0; req0_amt = '0; req1_amt = '0;
    @(negedge clock);

    for (int d = 0; d < 2; d++) begin
      do_reset(d);

      // Idle with no requests: nothing granted, shifter inputs quiet.
      for (int i = 0; i < 2; i++) begin
        @(negedge clock);
        check($sformatf("d%0d idle ready", d), {30'd0, req1_ready[d], req0_ready[d]}, 32'd0);
        check($sformatf("d%0d idle busy", d), {31'd0, busy[d]}, 32'd0);
        check($sformatf("d%0d idle sh_a", d), sh_a[d], mdl_sh_a[d]);
      end

      // Largest shift amount.
      run_op(d, 1'b1, 32'h0000_0001, 5'd31, 1'b0, 32'h0, 5'd0, 0);

      // Conflicts straight after reset: round-robin starts with req0 and then
      // alternates; fixed priority always serves req0.
      do_reset(d);
      for (int k = 0; k < 4; k++) begin
        run_op(d, 1'b1, 32'h0000_000F, 5'd4, 1'b1, 32'h0000_0003, 5'd1, 0);
      end

      // Response held back for five cycles.
      run_op(d, 1'b0, 32'h0, 5'd0, 1'b1, 32'hFFFF_FFFF, 5'd8, 5);

      // Zero shift amount.
      run_op(d, 1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h0, 5'd0, 0);

      // Reset while an op is in ISSUE: no response ever appears.
      req0_valid[d] = 1'b1; req0_a[d] = 32'h1234_5678; req0_amt[d] = 5'd3;
      #1;
      check($sformatf("d%0d pre-abort req0_ready", d), {31'd0, req0_ready[d]}, 32'd1);
      @(posedge clock);
      #1;
      req0_valid[d] = 1'b0;
      @(negedge clock);
      check($sformatf("d%0d abort in issue busy", d), {31'd0, busy[d]}, 32'd1);
      do_reset(d);
      @(negedge clock);
      check($sformatf("d%0d abort no rsp", d), {30'd0, rsp1_valid[d], rsp0_valid[d]}, 32'd0);
      run_op(d, 1'b1, 32'h0000_00A5, 5'd2, 1'b0, 32'h0, 5'd0, 0);

      // Random traffic.
      for (int k = 0; k < 30; k++) begin
        logic       v0, v1;
        logic [4:0] m0, m1;
        v0 = 1'($urandom);
        v1 = 1'($urandom);
        if (!v0 && !v1) v1 = 1'b1;
        m0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        m1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        run_op(d, v0, $urandom, m0, v1, $urandom, m1, $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

  // Hard stop in case a timing step above ever stalls.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
